// File: rtl/inv_cipher_round_ctrl.sv
// Round sequencer for the AES-128 inverse cipher: steps ARK/ISR/ISB/IMC stage units in InvCipher order.
// Optional WAIT-state watchdog enabled by defining INV_CTRL_WDOG_EN.
module inv_cipher_round_ctrl #(
   parameter int NR      = 10,
   parameter int TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       ark_done,
   input  logic       isr_done,
   input  logic       isb_done,
   input  logic       imc_done,
   output logic       en_ark,
   output logic       en_isr,
   output logic       en_isb,
   output logic       en_imc,
   output logic [1:0] op_sel,
   output logic       state_we,
   output logic [3:0] round_idx,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_GAP,
      S_FINISH
   } state_t;

   localparam logic [1:0] OP_ARK = 2'd0;
   localparam logic [1:0] OP_ISR = 2'd1;
   localparam logic [1:0] OP_ISB = 2'd2;
   localparam logic [1:0] OP_IMC = 2'd3;
   localparam logic [3:0] NR_IDX = 4'(NR);

   state_t     state_reg, state_next;
   logic [1:0] op_reg, op_next;
   logic [3:0] round_reg, round_next;
   logic [3:0] done_q_reg;
   logic [3:0] done_vec;
   logic [3:0] en_vec;
   logic       stage_active;
   logic       done_edge;

   assign done_vec     = {imc_done, isb_done, isr_done, ark_done};
   assign stage_active = (state_reg == S_ISSUE) || (state_reg == S_WAIT);
   // Only a fresh rising edge of the selected stage's done completes the op.
   assign done_edge    = done_vec[op_reg] & ~done_q_reg[op_reg];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_en
         assign en_vec[gi] = stage_active && (op_reg == 2'(gi));
      end
   endgenerate

   assign en_ark    = en_vec[0];
   assign en_isr    = en_vec[1];
   assign en_isb    = en_vec[2];
   assign en_imc    = en_vec[3];
   assign busy      = stage_active || (state_reg == S_GAP);
   assign op_sel    = busy ? op_reg : OP_ARK;
   assign state_we  = (state_reg == S_GAP);
   assign done      = (state_reg == S_FINISH);
   assign round_idx = round_reg;

`ifdef INV_CTRL_WDOG_EN
   logic [7:0] wdog_reg, wdog_next;
   logic       err_reg, err_next;
   assign err = err_reg;
`else
   assign err = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      op_next    = op_reg;
      round_next = round_reg;
`ifdef INV_CTRL_WDOG_EN
      wdog_next  = wdog_reg;
      err_next   = err_reg;
`endif
      case (state_reg)
         S_IDLE: begin
            if (start && !abort) begin
               state_next = S_ISSUE;
               op_next    = OP_ARK;
               round_next = NR_IDX;
`ifdef INV_CTRL_WDOG_EN
               err_next   = 1'b0;
`endif
            end
         end
         S_ISSUE: begin
            state_next = S_WAIT;
`ifdef INV_CTRL_WDOG_EN
            wdog_next  = 8'd0;
`endif
         end
         S_WAIT: begin
            if (done_edge) begin
               state_next = S_GAP;
`ifdef INV_CTRL_WDOG_EN
            end else if (wdog_reg == 8'(TIMEOUT - 1)) begin
               state_next = S_IDLE;
               err_next   = 1'b1;
            end else begin
               wdog_next  = wdog_reg + 8'd1;
`endif
            end
         end
         S_GAP: begin
            state_next = S_ISSUE;
            case (op_reg)
               OP_ARK: begin
                  if (round_reg == NR_IDX) begin
                     op_next    = OP_ISR;
                     round_next = NR_IDX - 4'd1;
                  end else if (round_reg != 4'd0) begin
                     op_next = OP_IMC;
                  end else begin
                     state_next = S_FINISH;
                  end
               end
               OP_ISR: op_next = OP_ISB;
               OP_ISB: op_next = OP_ARK;
               default: begin
                  op_next    = OP_ISR;
                  round_next = round_reg - 4'd1;
               end
            endcase
         end
         default: state_next = S_IDLE;
      endcase

      // Abort leaves round_idx and err exactly as they were.
      if (abort && (state_reg != S_IDLE)) begin
         state_next = S_IDLE;
         op_next    = op_reg;
         round_next = round_reg;
`ifdef INV_CTRL_WDOG_EN
         err_next   = err_reg;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg  <= S_IDLE;
         op_reg     <= OP_ARK;
         round_reg  <= 4'd0;
         done_q_reg <= 4'd0;
`ifdef INV_CTRL_WDOG_EN
         wdog_reg   <= 8'd0;
         err_reg    <= 1'b0;
`endif
      end else begin
         state_reg  <= state_next;
         op_reg     <= op_next;
         round_reg  <= round_next;
         done_q_reg <= done_vec;
`ifdef INV_CTRL_WDOG_EN
         wdog_reg   <= wdog_next;
         err_reg    <= err_next;
`endif
      end
   end

endmodule

// File: tb/tb_inv_cipher_round_ctrl.sv
// Scoreboard bench for inv_cipher_round_ctrl: random stage latencies, expected op trace built from the InvCipher order.
// Watchdog scenario is exercised only when INV_CTRL_WDOG_EN is defined.
module tb_inv_cipher_round_ctrl;

   localparam int NR      = 10;
   localparam int TIMEOUT = 20;
   localparam int N_OPS   = 4 * NR;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       ark_done, isr_done, isb_done, imc_done;
   logic       en_ark, en_isr, en_isb, en_imc;
   logic [1:0] op_sel;
   logic       state_we;
   logic [3:0] round_idx;
   logic       busy, done, err;

   inv_cipher_round_ctrl #(.NR(NR), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .ark_done(ark_done), .isr_done(isr_done), .isb_done(isb_done), .imc_done(imc_done),
      .en_ark(en_ark), .en_isr(en_isr), .en_isb(en_isb), .en_imc(en_imc),
      .op_sel(op_sel), .state_we(state_we), .round_idx(round_idx),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] op;
      logic [3:0] rnd;
   } step_t;

   step_t exp_q[$];
   int    vectors     = 0;
   int    miscompares = 0;
   int    strobes     = 0;
   int    dones       = 0;
   int    exp_dones   = 0;

   // Stage models: done rises a random 2..6 cycles after enable, falls with enable.
   logic [3:0] mdl = 4'd0;
   int         cnt[4];
   int         lat[4];
   logic       isb_never = 1'b0;
   logic       imc_mode  = 1'b0;
   logic       imc_force = 1'b0;

   assign ark_done = mdl[0];
   assign isr_done = mdl[1];
   assign isb_done = isb_never ? 1'b0 : mdl[2];
   assign imc_done = imc_mode ? imc_force : mdl[3];

   initial for (int i = 0; i < 4; i++) begin cnt[i] = 0; lat[i] = 2; end

   always @(negedge clk) begin
      logic [3:0] en_v;
      en_v = {en_imc, en_isb, en_isr, en_ark};
      for (int i = 0; i < 4; i++) begin
         if (en_v[i]) begin
            if (cnt[i] == 0) lat[i] = int'($urandom_range(2, 6));
            cnt[i] = cnt[i] + 1;
            mdl[i] = (cnt[i] >= lat[i]);
         end else begin
            cnt[i] = 0;
            mdl[i] = 1'b0;
         end
      end
   end

   task automatic check(input string name, input int act, input int expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   // Reference trace: ARK(NR), then ISR,ISB,ARK,IMC for rounds NR-1..1, then ISR,ISB,ARK(0).
   task automatic push_expected();
      step_t s;
      s.op = 2'd0; s.rnd = 4'(NR); exp_q.push_back(s);
      for (int r = NR - 1; r >= 0; r--) begin
         s.rnd = 4'(r);
         s.op = 2'd1; exp_q.push_back(s);
         s.op = 2'd2; exp_q.push_back(s);
         s.op = 2'd0; exp_q.push_back(s);
         if (r != 0) begin s.op = 2'd3; exp_q.push_back(s); end
      end
   endtask

   // Monitor: pops one expected step per state_we strobe.
   always @(negedge clk) begin
      logic [3:0] en_v;
      step_t      e;
      if (rst) begin
         en_v = {en_imc, en_isb, en_isr, en_ark};
         if (en_v != 4'd0) begin
            if (exp_q.size() == 0) check("enable_without_expected_op", int'(en_v), 0);
            else check("enable_onehot", int'(en_v), 1 << exp_q[0].op);
         end
         if (state_we) begin
            strobes++;
            if (exp_q.size() == 0) begin
               check("unexpected_strobe", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("op_sel", int'(op_sel), int'(e.op));
               check("round_idx", int'(round_idx), int'(e.rnd));
            end
         end
         if (done) begin
            dones++;
            check("queue_empty_at_done", exp_q.size(), 0);
         end
      end
   end

   task automatic start_run();
      @(negedge clk);
      push_expected();
      strobes = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", int'(busy), 1);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      exp_dones++;
      check("done_seen", int'(done), 1);
      check("strobes_per_run", strobes, N_OPS);
      check("err_at_done", int'(err), 0);
      @(negedge clk);
      check("done_one_cycle", int'(done), 0);
      check("idle_after_done", int'(busy), 0);
   endtask

   task automatic wait_for(input int which, output int ok);
      int n = 0;
      logic [3:0] en_v;
      ok = 0;
      while (n < 2000) begin
         en_v = {en_imc, en_isb, en_isr, en_ark};
         if (en_v[which]) begin ok = 1; break; end
         @(negedge clk);
         n++;
      end
      check("enable_reached", ok, 1);
   endtask

   initial begin
      int ok;
      int n;

      // Reset with start held: nothing may move.
      rst = 1'b0; start = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("reset_outputs", int'({en_ark, en_isr, en_isb, en_imc, op_sel, state_we, round_idx, busy, done, err}), 0);
      end
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("idle_busy", int'(busy), 0);

      // Plain full run.
      start_run();
      wait_done();

      // Stale imc_done held high through the first IMC issue.
      imc_mode = 1'b1; imc_force = 1'b1;
      start_run();
      wait_for(3, ok);
      if (ok != 0) begin
         repeat (8) @(negedge clk);
         check("stale_done_hold", int'(en_imc), 1);
         check("stale_no_advance", strobes, 4);
         imc_force = 1'b0;
         @(negedge clk);
         imc_force = 1'b1;
         @(negedge clk);
      end
      imc_mode = 1'b0;
      wait_done();

      // start pulsed during the 5th op is ignored.
      start_run();
      n = 0;
      while (strobes < 4 && n < 2000) begin @(negedge clk); n++; end
      check("reached_op5", strobes, 4);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();

      // Abort in round 5 WAIT.
      start_run();
      n = 0;
      while (!(en_isr && round_idx == 4'd5) && n < 2000) begin @(negedge clk); n++; end
      check("reached_round5", int'(round_idx), 5);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", int'(busy), 0);
      check("abort_enables", int'({en_ark, en_isr, en_isb, en_imc, state_we}), 0);
      check("abort_no_done", int'(done), 0);
      check("abort_round_hold", int'(round_idx), 5);
      exp_q.delete();
      start_run();
      wait_done();

      // Extra random-latency runs.
      repeat (2) begin
         start_run();
         wait_done();
      end

`ifdef INV_CTRL_WDOG_EN
      // Watchdog: ISB never answers.
      isb_never = 1'b1;
      start_run();
      wait_for(2, ok);
      n = 0;
      while (en_isb && n < 100) begin @(negedge clk); n++; end
      check("wdog_enable_cycles", n, TIMEOUT + 1);
      check("wdog_err", int'(err), 1);
      check("wdog_idle", int'(busy), 0);
      exp_q.delete();
      isb_never = 1'b0;
      start_run();
      check("err_cleared", int'(err), 0);
      wait_done();
`endif

      check("done_pulses", dones, exp_dones);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
